draw_arbiter: RTL and testbench

//  Shares the single VGA plot port between the sprite sources (rocket, shot, aliens).

---
 rtl/draw_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_draw_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_arbiter.sv
// ---------------------------------------------------------------------------
// draw_arbiter
//   Shares the single VGA plot port between several sprite sources. Each
//   source requests a filled rectangle; requests are granted round-robin and
//   the granted rectangle is scanned in raster order, one pixel per clock,
//   after which a one-cycle done pulse is returned to that source.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   reset_i        asynchronous, active-high reset
//   req_i          per-source draw request level (index 0 has first turn)
//   req_x_i        top-left x, source i in [i*XW +: XW]
//   req_y_i        top-left y, source i in [i*YW +: YW]
//   req_colour_i   fill colour, source i in [i*CW +: CW] (0 = erase)
//   req_w_i        width-1,  source i in [i*SW +: SW]
//   req_h_i        height-1, source i in [i*SW +: SW]
//   grant_o        one-hot, high from LATCH through the DONE cycle
//   done_o         one-cycle pulse to the served source
//   vga_x_o        plot x (holds when vga_plot_o is low)
//   vga_y_o        plot y (holds when vga_plot_o is low)
//   vga_colour_o   plot colour (holds when vga_plot_o is low)
//   vga_plot_o     plot enable
//   busy_o         high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module draw_arbiter #(
  parameter int NREQ = 3,
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int CW   = 3,
  parameter int SW   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*XW-1:0] req_x_i,
  input  logic [NREQ*YW-1:0] req_y_i,
  input  logic [NREQ*CW-1:0] req_colour_i,
  input  logic [NREQ*SW-1:0] req_w_i,
  input  logic [NREQ*SW-1:0] req_h_i,
  output logic [NREQ-1:0]    grant_o,
  output logic [NREQ-1:0]    done_o,
  output logic [XW-1:0]      vga_x_o,
  output logic [YW-1:0]      vga_y_o,
  output logic [CW-1:0]      vga_colour_o,
  output logic               vga_plot_o,
  output logic               busy_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [XW-1:0]     x0_q, x0_d;
  logic [YW-1:0]     y0_q, y0_d;
  logic [CW-1:0]     col_q, col_d;
  logic [SW-1:0]     w_q, w_d;
  logic [SW-1:0]     h_q, h_d;
  logic [SW-1:0]     cx_q, cx_d;
  logic [SW-1:0]     cy_q, cy_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [XW-1:0]     vx_q, vx_d;
  logic [YW-1:0]     vy_q, vy_d;
  logic [CW-1:0]     vc_q, vc_d;
  logic              plot_q, plot_d;
  logic              busy_q, busy_d;

  logic              found_s;
  logic [IW-1:0]     pick_s;
  logic [IW-1:0]     cand_s;
  logic [SW-1:0]     cx_n_s;
  logic [SW-1:0]     cy_n_s;

  // Round-robin pick: first requesting index after last_q, wrapping around.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IW'((int'(last_q) + k) % NREQ);
      if (!found_s && req_i[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead so
  // that the registered vga_* values line up with the pixel being drawn.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gidx_d  = gidx_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    col_d   = col_q;
    w_d     = w_q;
    h_d     = h_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    grant_d = grant_q;
    done_d  = '0;
    vx_d    = vx_q;
    vy_d    = vy_q;
    vc_d    = vc_q;
    plot_d  = 1'b0;
    cx_n_s  = '0;
    cy_n_s  = '0;

    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          gidx_d  = pick_s;
          grant_d = NREQ'(1'b1) << pick_s;
          state_d = S_LATCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        // Fields are sampled only here; later changes on the inputs are ignored.
        x0_d    = req_x_i[int'(gidx_q)*XW +: XW];
        y0_d    = req_y_i[int'(gidx_q)*YW +: YW];
        col_d   = req_colour_i[int'(gidx_q)*CW +: CW];
        w_d     = req_w_i[int'(gidx_q)*SW +: SW];
        h_d     = req_h_i[int'(gidx_q)*SW +: SW];
        cx_d    = '0;
        cy_d    = '0;
        // Present pixel (0,0) in the first DRAW cycle.
        vx_d    = req_x_i[int'(gidx_q)*XW +: XW];
        vy_d    = req_y_i[int'(gidx_q)*YW +: YW];
        vc_d    = req_colour_i[int'(gidx_q)*CW +: CW];
        plot_d  = 1'b1;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        // cx_q/cy_q name the pixel currently on the output registers.
        if ((cx_q == w_q) && (cy_q == h_q)) begin
          done_d  = grant_q;
          state_d = S_DONE;
        end else begin
          if (cx_q == w_q) begin
            cx_n_s = '0;
            cy_n_s = cy_q + SW'(1'b1);
          end else begin
            cx_n_s = cx_q + SW'(1'b1);
            cy_n_s = cy_q;
          end
          cx_d    = cx_n_s;
          cy_d    = cy_n_s;
          // Coordinates wrap modulo the port width; no clipping.
          vx_d    = x0_q + XW'(cx_n_s);
          vy_d    = y0_q + YW'(cy_n_s);
          plot_d  = 1'b1;
          state_d = S_DRAW;
        end
      end
      S_DONE: begin
        last_d  = gidx_q;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any draw without a done pulse.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NREQ - 1);
      gidx_q  <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      col_q   <= '0;
      w_q     <= '0;
      h_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      grant_q <= '0;
      done_q  <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      col_q   <= col_d;
      w_q     <= w_d;
      h_q     <= h_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_o      = grant_q;
  assign done_o       = done_q;
  assign vga_x_o      = vx_q;
  assign vga_y_o      = vy_q;
  assign vga_colour_o = vc_q;
  assign vga_plot_o   = plot_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Scoreboard bench for draw_arbiter: stimulus pushes expected grants, grant
// lengths, pixels and done pulses; a negedge monitor pops and compares them.
module tb_draw_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;
  logic [11:0] req_w;
  logic [11:0] req_h;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;

  draw_arbiter dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_i        (req),
    .req_x_i      (req_x),
    .req_y_i      (req_y),
    .req_colour_i (req_colour),
    .req_w_i      (req_w),
    .req_h_i      (req_h),
    .grant_o      (grant),
    .done_o       (done),
    .vga_x_o      (vga_x),
    .vga_y_o      (vga_y),
    .vga_colour_o (vga_colour),
    .vga_plot_o   (vga_plot),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t       exp_pix[$];
  logic [2:0] exp_done[$];
  logic [2:0] exp_grant[$];
  int         exp_glen[$];

  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  logic [2:0] prev_grant = 3'b000;
  int   glen = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input int x, input int y, input int c, input int w, input int h);
    req_x[i*8 +: 8]      = 8'(x);
    req_y[i*7 +: 7]      = 7'(y);
    req_colour[i*3 +: 3] = 3'(c);
    req_w[i*4 +: 4]      = 4'(w);
    req_h[i*4 +: 4]      = 4'(h);
  endtask

  task automatic push_pix(input int x, input int y, input int c);
    pix_t p;
    p.x = 8'(x);
    p.y = 7'(y);
    p.c = 3'(c);
    exp_pix.push_back(p);
  endtask

  // One grant of a single-pixel rectangle.
  task automatic push_single(input logic [2:0] g, input int x, input int y, input int c);
    exp_grant.push_back(g);
    exp_glen.push_back(3);
    push_pix(x, y, c);
    exp_done.push_back(g);
  endtask

  // Wait (bounded) until done is seen just after a rising edge.
  task automatic wait_done(input int budget, output logic [2:0] d);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((done == 3'b000) && (n < budget));
    d = done;
    if (done == 3'b000) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got 0 expected nonzero after %0d cycles", n);
    end
  endtask

  // Monitor: compares DUT activity against the expectation queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if ((grant != 3'b000) && (prev_grant == 3'b000)) begin
        if (exp_grant.size() == 0) check("grant_unexpected", 32'(grant), 32'd0);
        else check("grant", 32'(grant), 32'(exp_grant.pop_front()));
        glen <= 1;
      end else if (grant != 3'b000) begin
        glen <= glen + 1;
      end else if (prev_grant != 3'b000) begin
        if (exp_glen.size() == 0) check("grant_len_unexpected", 32'(glen), 32'd0);
        else check("grant_len", 32'(glen), 32'(exp_glen.pop_front()));
      end
      if (vga_plot) begin
        if (exp_pix.size() == 0) begin
          check("plot_unexpected", 32'(vga_plot), 32'd0);
        end else begin
          pix_t p;
          p = exp_pix.pop_front();
          check("pix_x", 32'(vga_x), 32'(p.x));
          check("pix_y", 32'(vga_y), 32'(p.y));
          check("pix_colour", 32'(vga_colour), 32'(p.c));
        end
      end
      if (done != 3'b000) begin
        if (exp_done.size() == 0) check("done_unexpected", 32'(done), 32'd0);
        else check("done", 32'(done), 32'(exp_done.pop_front()));
      end
    end
    prev_grant <= grant;
  end

  initial begin
    logic [2:0] d;
    reset = 1'b1;
    req = 3'b000;
    req_x = '0; req_y = '0; req_colour = '0; req_w = '0; req_h = '0;
    tick(); tick();
    // Reset state
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_x", 32'(vga_x), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    // Test 1: single pixel, cycle-exact latency
    set_src(0, 10, 20, 7, 0, 0);
    push_single(3'b001, 10, 20, 7);
    req = 3'b001;                       // cycle 0
    tick();                             // cycle 1
    check("t1_grant_c1", 32'(grant), 32'd1);
    check("t1_plot_c1", 32'(vga_plot), 32'd0);
    check("t1_busy_c1", 32'(busy), 32'd1);
    tick();                             // cycle 2
    check("t1_plot_c2", 32'(vga_plot), 32'd1);
    check("t1_x_c2", 32'(vga_x), 32'd10);
    check("t1_y_c2", 32'(vga_y), 32'd20);
    tick();                             // cycle 3
    check("t1_done_c3", 32'(done), 32'd1);
    check("t1_plot_c3", 32'(vga_plot), 32'd0);
    check("t1_grant_c3", 32'(grant), 32'd1);
    req = 3'b000;
    tick();                             // cycle 4
    check("t1_grant_c4", 32'(grant), 32'd0);
    check("t1_busy_c4", 32'(busy), 32'd0);
    check("t1_done_c4", 32'(done), 32'd0);
    check("t1_hold_x", 32'(vga_x), 32'd10);

    // Test 2: all three requesting, fresh reset -> order 0,1,2,0,1
    reset = 1'b1; tick(); reset = 1'b0; tick();
    set_src(0, 1, 1, 1, 0, 0);
    set_src(1, 2, 2, 2, 0, 0);
    set_src(2, 3, 3, 3, 0, 0);
    push_single(3'b001, 1, 1, 1);
    push_single(3'b010, 2, 2, 2);
    push_single(3'b100, 3, 3, 3);
    push_single(3'b001, 1, 1, 1);
    push_single(3'b010, 2, 2, 2);
    req = 3'b111;
    for (int n = 0; n < 5; n++) begin
      wait_done(20, d);
    end
    req = 3'b000;
    tick(); tick();

    // Test 3: wrapping 3x2 rectangle from source 1
    set_src(1, 254, 126, 5, 2, 1);
    exp_grant.push_back(3'b010);
    exp_glen.push_back(8);
    push_pix(254, 126, 5); push_pix(255, 126, 5); push_pix(0, 126, 5);
    push_pix(254, 127, 5); push_pix(255, 127, 5); push_pix(0, 127, 5);
    exp_done.push_back(3'b010);
    req = 3'b010;
    wait_done(30, d);
    req = 3'b000;
    tick(); tick();

    // Test 4: req2 held, req1 pulses after each of its dones (last=1 -> 2 first)
    set_src(1, 5, 5, 2, 0, 0);
    set_src(2, 7, 7, 4, 1, 0);
    for (int n = 0; n < 2; n++) begin
      exp_grant.push_back(3'b100);
      exp_glen.push_back(4);
      push_pix(7, 7, 4);
      push_pix(8, 7, 4);
      exp_done.push_back(3'b100);
      push_single(3'b010, 5, 5, 2);
    end
    req = 3'b110;
    for (int n = 0; n < 4; n++) begin
      wait_done(30, d);
      if (n == 3) begin
        req = 3'b000;
      end else if (d == 3'b010) begin
        req[1] = 1'b0;
        tick();
        req[1] = 1'b1;
      end
    end
    tick(); tick();

    // Test 6: drop req0 and change x0 after LATCH
    set_src(0, 50, 10, 3, 1, 1);
    exp_grant.push_back(3'b001);
    exp_glen.push_back(6);
    push_pix(50, 10, 3); push_pix(51, 10, 3);
    push_pix(50, 11, 3); push_pix(51, 11, 3);
    exp_done.push_back(3'b001);
    req = 3'b001;                       // cycle 0
    tick();                             // cycle 1 (LATCH)
    tick();                             // cycle 2 (first plot)
    req = 3'b000;
    req_x[7:0] = 8'd99;
    wait_done(30, d);
    tick(); tick();

    // Test 5: reset during the 3rd plot of a 4x4 draw
    check("q_pix_empty_pre5", 32'(exp_pix.size()), 32'd0);
    check("q_done_empty_pre5", 32'(exp_done.size()), 32'd0);
    mon_en = 1'b0;
    set_src(0, 60, 40, 6, 3, 3);
    req = 3'b001;                       // cycle 0
    tick(); tick(); tick(); tick();     // cycle 4: third plot
    check("t5_plot3", 32'(vga_plot), 32'd1);
    check("t5_plot3_x", 32'(vga_x), 32'd62);
    reset = 1'b1;
    req = 3'b000;
    #1;
    check("t5_rst_plot", 32'(vga_plot), 32'd0);
    check("t5_rst_grant", 32'(grant), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
    tick();
    set_src(1, 40, 30, 6, 0, 0);
    push_single(3'b010, 40, 30, 6);
    req = 3'b010;
    wait_done(20, d);
    req = 3'b000;
    tick(); tick(); tick();

    check("q_pix_empty", 32'(exp_pix.size()), 32'd0);
    check("q_done_empty", 32'(exp_done.size()), 32'd0);
    check("q_grant_empty", 32'(exp_grant.size()), 32'd0);
    check("q_glen_empty", 32'(exp_glen.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
